rv_instr_encoder: RTL and testbench
===================================

Name: rv_instr_encoder

Overview:
- Inverse of the main control decoder. Takes decoded instruction fields (class, registers, funct, immediate) and assembles the 32-bit RV32I machine word.
- Writes each word into instruction memory at consecutive word addresses over a valid/ready input handshake and a held write request to memory.
- Serves as the program loader in front of instruction memory for test and boot.

Parameters:
- ADDR_W, 10, word-address width of instruction memory; capacity 2^ADDR_W words.
- BASE_ADDR, 0, first word address written after reset/start (ADDR_W bits).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  synchronous clear: pointer to BASE_ADDR, count 0, abort pending write
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept fields
- in_kind  in  3  0=R, 1=I(ALU), 2=S, 3=B, 4=J(jal), 5=U(lui), 6=LW, 7=JALR
- in_funct3  in  3  funct3 (ignored for LW/JALR/J/U)
- in_funct7  in  7  funct7 (R; I shifts)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  immediate, sign-extended byte offset (U: full value, low 12 bits expected 0)
- mem_we  out  1  write request to instruction memory
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  memory accepts write this cycle
- count  out  ADDR_W+1  words written since reset/start
- full  out  1  count == 2^ADDR_W
- err  out  1  sticky encoding error (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async): state IDLE, mem_we=0, mem_wdata=0, mem_addr=BASE_ADDR, count=0, full=0, err=0. in_ready=1 after release.
- FSM states: IDLE, WRITE, FULL.
- IDLE: in_ready=1. On in_valid & in_ready at edge N, register the encoded word and go to WRITE. mem_we=1 from cycle N+1.
- WRITE: in_ready=0. mem_we, mem_addr and mem_wdata are held stable until mem_ready=1 is sampled. On that edge: mem_we drops, count+1, mem_addr+1 (mod 2^ADDR_W). Next state is FULL if the new count == 2^ADDR_W, else IDLE.
- Throughput: at most one word per 2 cycles when mem_ready=1.
- FULL: in_ready=0, full=1, mem_we=0. Stays until start or reset.
- start has priority over every other event in every state. On the next edge: state IDLE, mem_we=0, count=0, full=0, mem_addr=BASE_ADDR, err=0. A write in progress is aborted and not counted. An in_valid in the same cycle as start is not accepted.
- Encoding, opcode in [6:0]:
  - R: funct7|rs2|rs1|f3|rd|0110011
  - I: imm[11:0]|rs1|f3|rd|0010011. If f3=001 or 101, bits [31:25]=funct7 and [24:20]=imm[4:0].
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|0100011
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|1100011
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111
  - U: imm[31:12]|rd|0110111
  - LW: I layout, f3 forced 010, opcode 0000011
  - JALR: I layout, f3 forced 000, opcode 1100111
- Fields not used by a format are ignored. Immediate bits outside the format are silently truncated.

Optional Feature:
- Macro ENC_RANGE_CHECK_EN.
- When defined, err is set (sticky until start/reset) on acceptance if any of these hold:
  - I/S/LW/JALR imm is not in [-2048, 2047]
  - B imm is not in [-4096, 4094] or imm[0]=1
  - J imm is not in [-2^20, 2^20-2] or imm[0]=1
  - U imm[11:0] != 0
  - I shift with imm[11:5] nonzero
- The truncated word is still written.
- When not defined, err is tied to 0 and no check logic is built.

Test Plan:
- addi x1,x0,5 (kind=1, f3=0, rd=1, rs1=0, imm=5), mem_ready=1 -> one cycle after acceptance mem_we=1, addr=0, wdata=0x00500093; count=1 next edge.
- add x3,x1,x2 then beq x1,x2,-4 (imm=0xFFFFFFFC) back to back -> 0x002081B3 at addr 0, 0xFE208EE3 at addr 1; in_ready low during each WRITE.
- jal x1,8 with mem_ready low for 3 cycles -> mem_we/addr/wdata=0x008000EF stable for 4 cycles, in_ready=0, count increments only on the ready edge.
- ADDR_W=2: 4 writes -> full=1, count=4, in_ready=0. Fifth in_valid is ignored. start -> count=0, mem_addr=0, in_ready=1.
- start asserted during WRITE with mem_ready=0 -> mem_we=0 next cycle, count unchanged at 0, the next instruction is written to BASE_ADDR.
- ENC_RANGE_CHECK_EN defined: addi imm=2048 -> err=1, wdata=0x80000013 (rd=0, rs1=0). Without the macro -> err stays 0.

Source files
------------

// File: rtl/rv_instr_encoder_if.sv
// Bus bundle for rv_instr_encoder: decoded-field input handshake, instruction
// memory write port and loader status. ADDR_W sets the memory word-address width.
interface rv_instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    modport master (
        output start, in_valid, in_kind, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err
    );

    modport slave (
        input  start, in_valid, in_kind, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, count, full, err
    );
endinterface

// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder / program loader: assembles machine words from decoded
// fields and writes them to consecutive instruction-memory words. Optional immediate
// range checking is built only when ENC_RANGE_CHECK_EN is defined.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for fields; in_ready high
// S_WRITE | encoded word held on the memory port until mem_ready
// S_FULL  | all 2^ADDR_W words written; waits for start or reset
module rv_instr_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    rv_instr_encoder_if.slave  bus
);
    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_J    = 7'b1101111;
    localparam logic [6:0] OP_U    = 7'b0110111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_FULL
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_wdata;
    logic [31:0]       w_wdata_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_nxt;
    logic [ADDR_W:0]   w_count_inc;
    logic [31:0]       w_enc;
    logic              w_is_shift;
    logic              w_accept;

    assign w_is_shift  = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101);
    assign w_count_inc = r_count + 1'b1;

    // start blocks acceptance even while idle, so ready drops with it
    assign bus.in_ready = (r_state == S_IDLE) && !bus.start;
    assign w_accept     = bus.in_valid && bus.in_ready;

    always_comb begin
        w_enc = '0;
        case (bus.in_kind)
            3'd0: w_enc = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                           bus.in_rd, OP_R};
            3'd1: begin
                if (w_is_shift) begin
                    w_enc = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1, bus.in_funct3,
                             bus.in_rd, OP_I};
                end else begin
                    w_enc = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                             bus.in_rd, OP_I};
                end
            end
            3'd2: w_enc = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                           bus.in_imm[4:0], OP_S};
            3'd3: w_enc = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                           bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], OP_B};
            3'd4: w_enc = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                           bus.in_imm[19:12], bus.in_rd, OP_J};
            3'd5: w_enc = {bus.in_imm[31:12], bus.in_rd, OP_U};
            3'd6: w_enc = {bus.in_imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, OP_LW};
            default: w_enc = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, OP_JALR};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wdata <= '0;
            r_addr  <= BASE_ADDR;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wdata <= w_wdata_nxt;
            r_addr  <= w_addr_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wdata_nxt = r_wdata;
        w_addr_nxt  = r_addr;
        w_count_nxt = r_count;
        if (bus.start) begin
            // abort drops the held word; it is never counted
            w_state_nxt = S_IDLE;
            w_wdata_nxt = '0;
            w_addr_nxt  = BASE_ADDR;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_wdata_nxt = w_enc;
                        w_state_nxt = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.mem_ready) begin
                        w_count_nxt = w_count_inc;
                        w_addr_nxt  = r_addr + 1'b1;
                        w_state_nxt = (w_count_inc == CAP) ? S_FULL : S_IDLE;
                    end
                end
                S_FULL: w_state_nxt = S_FULL;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.mem_we    = (r_state == S_WRITE);
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.count     = r_count;
    assign bus.full      = (r_state == S_FULL);

`ifdef ENC_RANGE_CHECK_EN
    logic signed [31:0] w_imm_s;
    logic               w_range_bad;
    logic               r_err;

    assign w_imm_s = $signed(bus.in_imm);

    always_comb begin
        w_range_bad = 1'b0;
        case (bus.in_kind)
            3'd1: w_range_bad = (w_imm_s < -32'sd2048) || (w_imm_s > 32'sd2047) ||
                                (w_is_shift && (bus.in_imm[11:5] != 7'd0));
            3'd2, 3'd6, 3'd7:
                  w_range_bad = (w_imm_s < -32'sd2048) || (w_imm_s > 32'sd2047);
            3'd3: w_range_bad = (w_imm_s < -32'sd4096) || (w_imm_s > 32'sd4094) ||
                                bus.in_imm[0];
            3'd4: w_range_bad = (w_imm_s < -32'sd1048576) || (w_imm_s > 32'sd1048574) ||
                                bus.in_imm[0];
            3'd5: w_range_bad = (bus.in_imm[11:0] != 12'd0);
            default: w_range_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (bus.start) begin
            r_err <= 1'b0;
        end else if (w_accept && w_range_bad) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_rv_instr_encoder.sv
// Scoreboard bench for rv_instr_encoder: directed test-plan cases then random fields,
// checked against a field-arithmetic reference encoder and a write-count model.
module tb_rv_instr_encoder;
    localparam int                AW   = 2;
    localparam logic [AW-1:0]     BASE = 2'd2;
    localparam int                CAP  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv_instr_encoder_if #(.ADDR_W(AW)) bus ();

    rv_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int unsigned addr;
        logic [31:0] word;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_count = 0;
    bit   m_err   = 1'b0;
    bit   mon_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned bits(input int unsigned u, input int hi, input int lo);
        return (u >> lo) & ((32'h1 << (hi - lo + 1)) - 1);
    endfunction

    function automatic int unsigned itype(input int unsigned imm12, input int rs1,
                                          input int f3, input int rd, input int opc);
        return (imm12 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
    endfunction

    function automatic logic [31:0] ref_encode(input int kind, input int f3, input int f7,
                                               input int rd, input int rs1, input int rs2,
                                               input logic [31:0] imm);
        int unsigned u;
        int unsigned w;
        u = imm;
        case (kind)
            0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
            1: if (f3 == 1 || f3 == 5) w = itype(f7 * 32 + bits(u, 4, 0), rs1, f3, rd, 'h13);
               else                    w = itype(bits(u, 11, 0), rs1, f3, rd, 'h13);
            2: w = (bits(u, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                   (bits(u, 4, 0) << 7) | 'h23;
            3: w = (bits(u, 12, 12) << 31) | (bits(u, 10, 5) << 25) | (rs2 << 20) |
                   (rs1 << 15) | (f3 << 12) | (bits(u, 4, 1) << 8) |
                   (bits(u, 11, 11) << 7) | 'h63;
            4: w = (bits(u, 20, 20) << 31) | (bits(u, 10, 1) << 21) |
                   (bits(u, 11, 11) << 20) | (bits(u, 19, 12) << 12) | (rd << 7) | 'h6F;
            5: w = (u & 32'hFFFF_F000) | (rd << 7) | 'h37;
            6: w = itype(bits(u, 11, 0), rs1, 2, rd, 'h03);
            default: w = itype(bits(u, 11, 0), rs1, 0, rd, 'h67);
        endcase
        return w;
    endfunction

    function automatic bit ref_bad(input int kind, input int f3, input logic [31:0] imm);
        int s;
        bit b;
        s = $signed(imm);
        case (kind)
            1: b = (s < -2048) || (s > 2047) || ((f3 == 1 || f3 == 5) && bits(imm, 11, 5) != 0);
            2, 6, 7: b = (s < -2048) || (s > 2047);
            3: b = (s < -4096) || (s > 4094) || imm[0];
            4: b = (s < -(1 << 20)) || (s > (1 << 20) - 2) || imm[0];
            5: b = (bits(imm, 11, 0) != 0);
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic cycle(input bit st, input bit v, input int kind, input int f3,
                         input int f7, input int rd, input int rs1, input int rs2,
                         input logic [31:0] imm, input bit mr, input bit use_lit,
                         input logic [31:0] lit, output bit acc);
        bit          rdy;
        logic [31:0] w;
        bit          bad;
        rdy = !st && (q.size() == 0) && (m_count != CAP);
        w   = use_lit ? lit : ref_encode(kind, f3, f7, rd, rs1, rs2, imm);
        bad = ref_bad(kind, f3, imm);
        bus.start     = st;
        bus.in_valid  = v;
        bus.in_kind   = kind[2:0];
        bus.in_funct3 = f3[2:0];
        bus.in_funct7 = f7[6:0];
        bus.in_rd     = rd[4:0];
        bus.in_rs1    = rs1[4:0];
        bus.in_rs2    = rs2[4:0];
        bus.in_imm    = imm;
        bus.mem_ready = st ? 1'b0 : mr;
        @(posedge clk);
        #1;
        acc = 1'b0;
        if (st) begin
            q.delete();
            m_count = 0;
            m_err   = 1'b0;
        end else if (v && rdy) begin
            acc = 1'b1;
            q.push_back('{addr: (int'(BASE) + m_count) % CAP, word: w});
`ifdef ENC_RANGE_CHECK_EN
            if (bad) m_err = 1'b1;
`endif
        end
    endtask

    task automatic idle(input int n, input bit mr);
        bit acc;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, mr, 0, 32'h0, acc);
    endtask

    task automatic do_start();
        bit acc;
        cycle(1, 1, 1, 0, 0, 1, 0, 0, 32'h5, 0, 0, 32'h0, acc);
        chk("start_blocks_valid", acc, 1'b0);
    endtask

    task automatic send(input int kind, input int f3, input int f7, input int rd,
                        input int rs1, input int rs2, input logic [31:0] imm,
                        input bit mr, input logic [31:0] lit);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++)
            cycle(0, 1, kind, f3, f7, rd, rs1, rs2, imm, mr, 1, lit, acc);
        if (!acc) chk("send_accept", 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mem_we", bus.mem_we, q.size() != 0);
            chk("in_ready", bus.in_ready, !bus.start && q.size() == 0 && m_count != CAP);
            chk("count", bus.count, m_count);
            chk("full", bus.full, m_count == CAP);
            chk("err", bus.err, m_err);
            if (bus.mem_we && q.size() > 0) begin
                chk("mem_addr", bus.mem_addr, q[0].addr);
                chk("mem_wdata", bus.mem_wdata, q[0].word);
                if (bus.mem_ready) begin
                    void'(q.pop_front());
                    m_count++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        bit          acc;
        bit          st, v, mr;
        int          kind;
        logic [31:0] imm;

        bus.start = 0; bus.in_valid = 0; bus.in_kind = 0; bus.in_funct3 = 0;
        bus.in_funct7 = 0; bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
        bus.in_imm = 0; bus.mem_ready = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, BASE);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_count", bus.count, 0);
        chk("rst_full", bus.full, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b1);
        mon_en = 1'b1;

        // addi x1,x0,5
        send(1, 0, 0, 1, 0, 0, 32'd5, 1, 32'h0050_0093);
        idle(1, 1);
        // add x3,x1,x2 then beq x1,x2,-4 back to back
        send(0, 0, 0, 3, 1, 2, 32'h0, 1, 32'h0020_81B3);
        send(3, 0, 0, 0, 1, 2, 32'hFFFF_FFFC, 1, 32'hFE20_8EE3);
        idle(1, 1);
        // jal x1,8 with memory stalled three cycles; fills the 4-word memory
        send(4, 0, 0, 1, 0, 0, 32'd8, 0, 32'h0080_00EF);
        idle(3, 0);
        idle(2, 1);
        chk("full_after_4", bus.full, 1'b1);
        cycle(0, 1, 1, 0, 0, 2, 0, 0, 32'd7, 1, 0, 32'h0, acc);
        chk("fifth_ignored", acc, 1'b0);
        idle(2, 1);
        do_start();
        chk("start_addr", bus.mem_addr, BASE);
        chk("start_count", bus.count, 0);
        // abort a stalled write, then the next word lands at BASE
        send(1, 0, 0, 4, 0, 0, 32'd9, 0, 32'h0090_0213);
        idle(1, 0);
        do_start();
        send(1, 0, 0, 5, 0, 0, 32'd1, 1, 32'h0010_0293);
        idle(2, 1);
        chk("abort_count", bus.count, 1);
        // addi x0,x0,2048 truncates to 0x800
        do_start();
        send(1, 0, 0, 0, 0, 0, 32'd2048, 1, 32'h8000_0013);
        idle(2, 1);
`ifdef ENC_RANGE_CHECK_EN
        chk("err_range", bus.err, 1'b1);
`else
        chk("err_off", bus.err, 1'b0);
`endif
        do_start();

        for (int i = 0; i < 600; i++) begin
            st   = (m_count == CAP) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
            v    = $urandom_range(0, 99) < 70;
            mr   = $urandom_range(0, 99) < 60;
            kind = $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = $urandom_range(0, 4095) - 2048;
                2: imm = ($urandom_range(0, 8191) - 4096) & ~32'h1;
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            cycle(st, v, kind, $urandom_range(0, 7), $urandom_range(0, 127),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  imm, mr, 0, 32'h0, acc);
        end

        idle(6, 1);
        chk("drain", q.size(), 0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
